// File: rtl/hack_dmem_responder_pkg.sv
// Shared constants and types for the Hack data-memory responder.
//   DATA_WIDTH   CPU data word width
//   SCREEN_BASE  first screen word address
//   KBD_ADDR     keyboard register address
//   SCR_ADDR_W   screen word offset width
//   scr_upd_t    screen-update FIFO entry {offset, pixel word}
package hack_dmem_responder_pkg;
  localparam int          DATA_WIDTH  = 16;
  localparam int          SCR_ADDR_W  = 13;
  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;
  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

  typedef struct packed {
    logic [SCR_ADDR_W-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } scr_upd_t;

  localparam int SCR_ENTRY_W = $bits(scr_upd_t);
endpackage

// File: rtl/hack_dmem_responder_sync_fifo.sv
// Synchronous FIFO, registered storage, head visible on dout_o.
//   clk_i/reset_i  clock, sync active-high reset (empties the FIFO)
//   push_i/din_i   write request; accepted when !full_o | pop_i
//   pop_i          remove head; caller qualifies it with !empty_o
//   dout_o         head entry
//   full_o/empty_o occupancy flags
module hack_dmem_responder_sync_fifo #(
  parameter int WIDTH      = 29,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Pointers carry one extra wrap bit: equal => empty, only wrap bit differs => full.
  logic [DEPTH_LOG2:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                   (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // When full, the slot being written is the head being popped this edge.
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && do_push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= din_i;
  end
endmodule

// File: rtl/hack_dmem_responder.sv
// Hack CPU data-memory responder: RAM, screen and keyboard map, with screen
// writes forwarded to the display engine through a small FIFO.
//   clk_i/reset_i              clock, sync active-high reset
//   addr_i/wr_en_i/wdata_i     CPU data port
//   rdata_o                    combinational read data (inM)
//   key_code_i                 keyboard scan code, registered into kbd_q
//   scr_valid_o/scr_ready_i    screen-update handshake
//   scr_addr_o/scr_data_o      head screen-update entry
//   scr_ovf_o/ovf_clr_i        sticky dropped-update flag and its clear
module hack_dmem_responder
  import hack_dmem_responder_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int DATA_W          = DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [14:0]           addr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o,
  input  logic [DATA_W-1:0]     key_code_i,
  output logic                  scr_valid_o,
  input  logic                  scr_ready_i,
  output logic [SCR_ADDR_W-1:0] scr_addr_o,
  output logic [DATA_W-1:0]     scr_data_o,
  output logic                  scr_ovf_o,
  input  logic                  ovf_clr_i
);
  logic [DATA_W-1:0] ram_q [2**14];
  logic [DATA_W-1:0] scr_q [2**SCR_ADDR_W];
  logic [DATA_W-1:0] kbd_q;
  logic ovf_q, ovf_d;

  logic sel_ram, sel_scr, sel_kbd;
  logic ram_we, scr_we, scr_pop, fifo_full, fifo_empty;
  scr_upd_t push_ent, head_ent;

  assign sel_ram = ~addr_i[14];
  assign sel_scr = (addr_i[14:13] == 2'b10);
  assign sel_kbd = (addr_i == KBD_ADDR);

  // Reset blocks every write, including array writes, in that cycle.
  assign ram_we = wr_en_i & sel_ram & ~reset_i;
  assign scr_we = wr_en_i & sel_scr & ~reset_i;

  always_comb begin
    rdata_o = ZERO_WORD;
    if (sel_ram)      rdata_o = ram_q[addr_i[13:0]];
    else if (sel_scr) rdata_o = scr_q[addr_i[SCR_ADDR_W-1:0]];
    else if (sel_kbd) rdata_o = kbd_q;
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) ram_q[addr_i[13:0]] <= wdata_i;
    if (scr_we) scr_q[addr_i[SCR_ADDR_W-1:0]] <= wdata_i;
  end

  // Offset within the screen window is just the low bits (base is aligned).
  assign push_ent.addr = addr_i[SCR_ADDR_W-1:0];
  assign push_ent.data = wdata_i;

  assign scr_valid_o = ~fifo_empty;
  assign scr_pop     = scr_valid_o & scr_ready_i;
  assign scr_addr_o  = head_ent.addr;
  assign scr_data_o  = head_ent.data;

  hack_dmem_responder_sync_fifo #(
    .WIDTH      (SCR_ENTRY_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (scr_we),
    .pop_i   (scr_pop),
    .din_i   (push_ent),
    .dout_o  (head_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Set beats clear when both happen in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (scr_we && fifo_full && !scr_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      kbd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      kbd_q <= key_code_i;
      ovf_q <= ovf_d;
    end
  end

  assign scr_ovf_o = ovf_q;
endmodule
